// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO read-side stream engine
package fifo_pkg;

  // Skid buffer occupancy states
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } fifo_lvl_e;

  // Two slots: one for the word being presented, one for the word returning from the FIFO
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry skid buffer with head/tail pointers and occupancy level
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  input  logic            pop,
  output logic [BITS-1:0] rd_data,
  output logic            valid,
  output logic [1:0]      level
);

  logic [BITS-1:0] r_mem [SKID_DEPTH];
  logic            r_head;
  logic            r_tail;
  fifo_lvl_e       r_lvl;
  fifo_lvl_e       w_lvl_nxt;

  // Next level: +1 per capture, -1 per pop; flush empties regardless of traffic
  always_comb begin
    w_lvl_nxt = r_lvl;
    if (flush) begin
      w_lvl_nxt = LVL_EMPTY;
    end else begin
      case (r_lvl)
        LVL_EMPTY: begin
          if (wr_en) w_lvl_nxt = LVL_ONE;
        end
        LVL_ONE: begin
          if (wr_en && !pop)      w_lvl_nxt = LVL_FULL;
          else if (!wr_en && pop) w_lvl_nxt = LVL_EMPTY;
        end
        LVL_FULL: begin
          if (pop && !wr_en) w_lvl_nxt = LVL_ONE;
        end
        default: w_lvl_nxt = LVL_EMPTY;
      endcase
    end
  end

  // Level state register
  always_ff @(posedge clk) begin
    if (rst) r_lvl <= LVL_EMPTY;
    else     r_lvl <= w_lvl_nxt;
  end

  // Storage and pointers; a flush rewinds both pointers so the buffer restarts clean
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (flush) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      if (wr_en) begin
        r_mem[r_tail] <= wr_data;
        r_tail        <= ~r_tail;
      end
      if (pop) r_head <= ~r_head;
    end
  end

  assign rd_data = r_mem[r_head];
  assign valid   = (r_lvl != LVL_EMPTY);
  assign level   = r_lvl;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream drain engine; beat counter under FIFO_RD_STREAM_CNT_EN
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                flush,
  output logic                fifo_rd_en,
  input  logic                fifo_rd_empty,
  input  logic [BITS-1:0]     fifo_rd_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BITS-1:0]     m_data,
  output logic [1:0]          buf_level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_BITS-1:0] beat_cnt
`endif
);

  logic       r_inflight;
  logic       w_pop;
  logic [2:0] w_owed;

  assign w_pop = m_valid & m_ready;

  // Slots still committed after this edge: held words plus the returning word minus the leaving one
  assign w_owed = {1'b0, buf_level} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign fifo_rd_en = !fifo_rd_empty && !flush && !rd_rst && (w_owed < 3'd2);

  // A read issued this cycle returns data on the next edge
  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_inflight <= 1'b0;
    else        r_inflight <= fifo_rd_en;
  end

  // The in-flight word is captured unless flush drops it inside the buffer
  fifo_rd_skid #(
    .BITS (BITS)
  ) u_skid (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .flush   (flush),
    .wr_en   (r_inflight),
    .wr_data (fifo_rd_data),
    .pop     (w_pop),
    .rd_data (m_data),
    .valid   (m_valid),
    .level   (buf_level)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_BITS-1:0] r_beat_cnt;

  // Delivered beats; a pop in a flush cycle still counts, flush never clears it
  always_ff @(posedge rd_clk) begin
    if (rd_rst)     r_beat_cnt <= '0;
    else if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
  end

  assign beat_cnt = r_beat_cnt;
`else
  // CNT_BITS only sizes the counter; keep it referenced when the counter is compiled out
  logic [31:0] w_unused_cnt_bits;
  assign w_unused_cnt_bits = 32'(CNT_BITS);
`endif

endmodule
